// File: rtl/salsa_stream_core.sv
// salsa_stream_core: Salsa20-family keystream generator. A START_ENC pulse
// produces one 512-bit block (ROUNDS rounds, one half-round per clock). The
// block is streamed out as 512/OUT_W chunks, lowest chunk first, over a
// valid/ready handshake.
// Optional build macro SALSA_PREFETCH_EN: adds a second 512-bit buffer. The
// next block (next counter value) is computed while the current one drains.
module salsa_stream_core #(
  parameter int ROUNDS = 20,
  parameter int OUT_W  = 128
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             SET_KEY,
  input  logic             SET_COUNT,
  input  logic             START_ENC,
  input  logic             KEY_LEN,
  input  logic [127:0]     DATA_IN,
  input  logic [255:0]     KEY_IN,
  input  logic             OUT_READY,
  output logic             BUSY,
  output logic             OUT_VALID,
  output logic             OUT_LAST,
  output logic [OUT_W-1:0] DATA_OUT,
  output logic             CTR_WRAP
);
  localparam int NCHUNK = 512 / OUT_W;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int HW     = $clog2(ROUNDS);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ROUND, S_FINAL, S_DRAIN} state_t;
  state_t state, nstate;

  logic [255:0]                 key_r;
  logic                         klen_r;
  logic [63:0]                  nonce_r, ctr_r;
  logic                         wrap_r;
  logic [15:0][31:0]            init_st, in_st, wk, sum_w;
  logic [HW-1:0]                hr;
  logic [511:0]                 out_buf;
  logic [NCHUNK-1:0][OUT_W-1:0] out_chk;
  logic                         drain_act;
  logic [CW-1:0]                cidx;
  logic                         cfg_ok, xfer, last_xfer, hr_done;
  logic [127:0]                 key_hi;

  function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
    logic [63:0] t;
    t = {x, x} << n;
    return t[63:32];
  endfunction

  // One half-round: four independent quarter-rounds on columns (row=0) or
  // rows (row=1). Quartet q starts on diagonal word 5q.
  function automatic logic [15:0][31:0] half_round(input logic [15:0][31:0] s,
                                                  input logic row);
    logic [15:0][31:0] r;
    logic [1:0]        qq;
    logic [3:0]        ia, ib, ic, id;
    r = s;
    for (int q = 0; q < 4; q++) begin
      qq = 2'(q);
      ia = {qq, qq};
      if (row) begin
        ib = {qq, qq + 2'd1};
        ic = {qq, qq + 2'd2};
        id = {qq, qq + 2'd3};
      end else begin
        ib = ia + 4'd4;
        ic = ia + 4'd8;
        id = ia + 4'd12;
      end
      r[ib] = r[ib] ^ rotl(r[ia] + r[id], 7);
      r[ic] = r[ic] ^ rotl(r[ib] + r[ia], 9);
      r[id] = r[id] ^ rotl(r[ic] + r[ib], 13);
      r[ia] = r[ia] ^ rotl(r[id] + r[ic], 18);
    end
    return r;
  endfunction

  // A 128-bit key fills both key slots with the same 128 bits.
  assign key_hi = klen_r ? key_r[127:0] : key_r[255:128];

  // Initial state in standard Salsa20 word order.
  always_comb begin
    init_st     = '0;
    init_st[0]  = 32'h61707865;
    init_st[1]  = key_r[31:0];
    init_st[2]  = key_r[63:32];
    init_st[3]  = key_r[95:64];
    init_st[4]  = key_r[127:96];
    init_st[5]  = klen_r ? 32'h3120646e : 32'h3320646e;
    init_st[6]  = nonce_r[31:0];
    init_st[7]  = nonce_r[63:32];
    init_st[8]  = ctr_r[31:0];
    init_st[9]  = ctr_r[63:32];
    init_st[10] = klen_r ? 32'h79622d36 : 32'h79622d32;
    init_st[11] = key_hi[31:0];
    init_st[12] = key_hi[63:32];
    init_st[13] = key_hi[95:64];
    init_st[14] = key_hi[127:96];
    init_st[15] = 32'h6b206574;
  end

  for (genvar g = 0; g < 16; g++) begin : g_sum
    assign sum_w[g] = wk[g] + in_st[g];
  end

  assign out_chk   = out_buf;
  assign DATA_OUT  = out_chk[cidx];
  assign OUT_VALID = drain_act;
  assign OUT_LAST  = drain_act && (cidx == CW'(NCHUNK - 1));
  assign CTR_WRAP  = wrap_r;
  assign xfer      = drain_act && OUT_READY;
  assign last_xfer = xfer && (cidx == CW'(NCHUNK - 1));
  assign hr_done   = (hr == HW'(ROUNDS - 1));

`ifdef SALSA_PREFETCH_EN
  logic [511:0] pf_buf;
  logic         pf_vld, pf_rel, pf_run;
  logic         start_new, release_pf, swap, pf_direct;

  assign BUSY   = (state != S_IDLE) || drain_act;
  assign cfg_ok = !BUSY;
  // A fresh block starts only when no prefetched block survives the cycle.
  assign start_new  = START_ENC && cfg_ok && (!pf_vld || SET_COUNT);
  // START_ENC with a prefetch pending (computing or held) releases it.
  assign release_pf = START_ENC && (pf_vld || pf_run) && !pf_rel && !start_new;
  // Held and released block moves into the output buffer once it frees up.
  assign swap       = pf_vld && pf_rel && (!drain_act || last_xfer) &&
                      !(cfg_ok && SET_COUNT);
  // Released prefetch finishing when the output is free bypasses the holder.
  assign pf_direct  = (state == S_FINAL) && pf_run && pf_rel &&
                      (!drain_act || last_xfer);
`else
  assign BUSY   = (state != S_IDLE);
  assign cfg_ok = !BUSY;
`endif

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= S_IDLE;
    else     state <= nstate;
  end

  // Next-state logic.
  always_comb begin
    nstate = state;
    case (state)
`ifdef SALSA_PREFETCH_EN
      S_IDLE:  if (start_new || swap) nstate = S_LOAD;
      S_FINAL: nstate = (!pf_run || pf_direct) ? S_LOAD : S_IDLE;
`else
      S_IDLE:  if (START_ENC) nstate = S_LOAD;
      S_FINAL: nstate = S_DRAIN;
`endif
      S_LOAD:  nstate = S_ROUND;
      S_ROUND: if (hr_done) nstate = S_FINAL;
      S_DRAIN: if (last_xfer) nstate = S_IDLE;
      default: nstate = S_IDLE;
    endcase
  end

  // Configuration registers, round datapath and output buffer(s).
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      key_r     <= '0;
      klen_r    <= 1'b0;
      nonce_r   <= '0;
      ctr_r     <= '0;
      wrap_r    <= 1'b0;
      in_st     <= '0;
      wk        <= '0;
      hr        <= '0;
      out_buf   <= '0;
      drain_act <= 1'b0;
      cidx      <= '0;
`ifdef SALSA_PREFETCH_EN
      pf_buf    <= '0;
      pf_vld    <= 1'b0;
      pf_rel    <= 1'b0;
      pf_run    <= 1'b0;
`endif
    end else begin
      if (cfg_ok && SET_KEY) begin
        key_r  <= KEY_IN;
        klen_r <= KEY_LEN;
      end
      if (cfg_ok && SET_COUNT) begin
        ctr_r   <= DATA_IN[127:64];
        nonce_r <= DATA_IN[63:0];
        wrap_r  <= 1'b0;
      end
      if (xfer) begin
        if (last_xfer) begin
          cidx      <= '0;
          drain_act <= 1'b0;
        end else begin
          cidx <= cidx + CW'(1);
        end
      end
      case (state)
        S_LOAD: begin
          in_st <= init_st;
          wk    <= init_st;
          hr    <= '0;
        end
        S_ROUND: begin
          wk <= half_round(wk, hr[0]);
          hr <= hr + HW'(1);
        end
        S_FINAL: begin
          ctr_r <= ctr_r + 64'd1;
          if (&ctr_r) wrap_r <= 1'b1;
`ifdef SALSA_PREFETCH_EN
          if (!pf_run || pf_direct) begin
            out_buf   <= sum_w;
            drain_act <= 1'b1;
            cidx      <= '0;
            pf_run    <= 1'b1;
            if (pf_direct) pf_rel <= 1'b0;
          end else begin
            pf_buf <= sum_w;
            pf_vld <= 1'b1;
            pf_run <= 1'b0;
          end
`else
          out_buf   <= sum_w;
          drain_act <= 1'b1;
          cidx      <= '0;
`endif
        end
        default: ;
      endcase
`ifdef SALSA_PREFETCH_EN
      if (cfg_ok && SET_COUNT) begin
        pf_vld <= 1'b0;
        pf_rel <= 1'b0;
      end
      if (release_pf) pf_rel <= 1'b1;
      if (start_new)  pf_run <= 1'b0;
      if (swap) begin
        out_buf   <= pf_buf;
        drain_act <= 1'b1;
        cidx      <= '0;
        pf_vld    <= 1'b0;
        pf_rel    <= 1'b0;
        pf_run    <= 1'b1;
      end
`endif
    end
  end
endmodule

// File: tb/tb_salsa_stream_core.sv
// tb_salsa_stream_core: two instances (OUT_W=128 and OUT_W=32) driven by the
// same configuration/start stimulus, compared against a plain Salsa20 model.
module tb_salsa_stream_core;
  logic         clk = 1'b0;
  logic         rst;
  logic         set_key, set_count, start_enc, key_len;
  logic [127:0] data_in;
  logic [255:0] key_in;
  logic         rdy, rdy32;
  logic         busy, vld, last, wrap;
  logic [127:0] dout;
  logic         busy32, vld32, last32, wrap32;
  logic [31:0]  dout32;

  always #5 clk = ~clk;

  salsa_stream_core #(.ROUNDS(20), .OUT_W(128)) u_dut (
    .CLK(clk), .RST(rst), .SET_KEY(set_key), .SET_COUNT(set_count),
    .START_ENC(start_enc), .KEY_LEN(key_len), .DATA_IN(data_in),
    .KEY_IN(key_in), .OUT_READY(rdy), .BUSY(busy), .OUT_VALID(vld),
    .OUT_LAST(last), .DATA_OUT(dout), .CTR_WRAP(wrap));

  salsa_stream_core #(.ROUNDS(20), .OUT_W(32)) u_dut32 (
    .CLK(clk), .RST(rst), .SET_KEY(set_key), .SET_COUNT(set_count),
    .START_ENC(start_enc), .KEY_LEN(key_len), .DATA_IN(data_in),
    .KEY_IN(key_in), .OUT_READY(rdy32), .BUSY(busy32), .OUT_VALID(vld32),
    .OUT_LAST(last32), .DATA_OUT(dout32), .CTR_WRAP(wrap32));

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: Salsa20 as written in the cipher definition.
  localparam int QI [8][4] = '{'{0, 4, 8, 12}, '{5, 9, 13, 1}, '{10, 14, 2, 6},
                               '{15, 3, 7, 11}, '{0, 1, 2, 3}, '{5, 6, 7, 4},
                               '{10, 11, 8, 9}, '{15, 12, 13, 14}};

  function automatic bit [31:0] rol(input bit [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic logic [511:0] salsa_ref(input logic [255:0] key, input logic klen,
                                             input logic [63:0] nonce, input logic [63:0] ctr);
    bit [31:0]    x [16];
    bit [31:0]    z [16];
    bit [255:0]   k2;
    logic [511:0] o;
    k2    = klen ? {key[127:0], key[127:0]} : key;
    x[0]  = 32'h61707865;
    x[5]  = klen ? 32'h3120646e : 32'h3320646e;
    x[10] = klen ? 32'h79622d36 : 32'h79622d32;
    x[15] = 32'h6b206574;
    for (int i = 0; i < 4; i++) begin
      x[1 + i]  = k2[32*i +: 32];
      x[11 + i] = k2[128 + 32*i +: 32];
    end
    x[6] = nonce[31:0]; x[7] = nonce[63:32];
    x[8] = ctr[31:0];   x[9] = ctr[63:32];
    z = x;
    for (int r = 0; r < 10; r++)
      for (int q = 0; q < 8; q++) begin
        z[QI[q][1]] ^= rol(z[QI[q][0]] + z[QI[q][3]], 7);
        z[QI[q][2]] ^= rol(z[QI[q][1]] + z[QI[q][0]], 9);
        z[QI[q][3]] ^= rol(z[QI[q][2]] + z[QI[q][1]], 13);
        z[QI[q][0]] ^= rol(z[QI[q][3]] + z[QI[q][2]], 18);
      end
    for (int i = 0; i < 16; i++) o[32*i +: 32] = z[i] + x[i];
    return o;
  endfunction

  logic [255:0] m_key;
  logic         m_klen;
  logic [63:0]  m_nonce, m_ctr;
  logic         m_wrap;

  logic [127:0] q128 [$];
  bit           l128 [$];
  logic [31:0]  q32  [$];
  bit           l32  [$];
  bit           hold128 = 0, hold32 = 0, lx128 = 0, lx32 = 0;
  logic [127:0] hd128;
  logic [31:0]  hd32;

  // Chunk collector / stall checker, 128-bit instance.
  always @(negedge clk) begin
    if (hold128) begin
      chk("stall_vld128", 512'(vld), 512'(1));
      chk("stall_data128", 512'(dout), 512'(hd128));
    end
    if (lx128) chk("busy_fall128", 512'(busy), 512'(0));
    if (vld) chk("busy_vld128", 512'(busy), 512'(1));
    hold128 = vld && !rdy;
    hd128   = dout;
    lx128   = vld && rdy && last;
    if (vld && rdy) begin q128.push_back(dout); l128.push_back(last); end
  end

  // Chunk collector / stall checker, 32-bit instance.
  always @(negedge clk) begin
    if (hold32) begin
      chk("stall_vld32", 512'(vld32), 512'(1));
      chk("stall_data32", 512'(dout32), 512'(hd32));
    end
    if (lx32) chk("busy_fall32", 512'(busy32), 512'(0));
    if (vld32) chk("busy_vld32", 512'(busy32), 512'(1));
    hold32 = vld32 && !rdy32;
    hd32   = dout32;
    lx32   = vld32 && rdy32 && last32;
    if (vld32 && rdy32) begin q32.push_back(dout32); l32.push_back(last32); end
  end

  // One block: optional config in the START cycle, an ignored pulse mid-block,
  // optional random backpressure, then full block / last-flag / wrap checks.
  task automatic run_block(input bit sk, input bit sc, input logic [255:0] key,
                           input bit kl, input logic [127:0] din, input bit bp,
                           output int lat);
    logic [511:0] exp, g128, g32;
    bit [3:0]     lm128;
    bit [15:0]    lm32;
    int           n;
    if (sk) begin m_key = key; m_klen = kl; end
    if (sc) begin m_ctr = din[127:64]; m_nonce = din[63:0]; m_wrap = 0; end
    exp = salsa_ref(m_key, m_klen, m_nonce, m_ctr);
    if (m_ctr == '1) m_wrap = 1;
    m_ctr = m_ctr + 64'd1;
    q128.delete(); l128.delete(); q32.delete(); l32.delete();
    set_key = sk; set_count = sc; start_enc = 1; key_in = key; key_len = kl; data_in = din;
    @(posedge clk); #1;
    set_key = 0; set_count = 0; start_enc = 0;
    lat = -1; n = 0;
    while (n < 600) begin
      rdy   = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      rdy32 = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (n == 3) begin
        set_key = 1; set_count = 1; start_enc = 1; key_len = ~kl;
        for (int i = 0; i < 8; i++) key_in[32*i +: 32] = $urandom;
        for (int i = 0; i < 4; i++) data_in[32*i +: 32] = $urandom;
      end else begin
        set_key = 0; set_count = 0; start_enc = 0;
      end
      @(posedge clk); #1;
      n++;
      if (lat < 0 && vld) lat = n;
      if (!busy && !busy32) break;
    end
    rdy = 1; rdy32 = 1;
    chk("timeout", 512'(busy | busy32), 512'(0));
    g128 = '0; g32 = '0; lm128 = '0; lm32 = '0;
    for (int k = 0; k < q128.size() && k < 4; k++) begin
      g128[128*k +: 128] = q128[k]; lm128[k] = l128[k];
    end
    for (int k = 0; k < q32.size() && k < 16; k++) begin
      g32[32*k +: 32] = q32[k]; lm32[k] = l32[k];
    end
    chk("nchunk128", 512'(q128.size()), 512'(4));
    chk("nchunk32", 512'(q32.size()), 512'(16));
    chk("block128", g128, exp);
    chk("block32", g32, exp);
    chk("last128", 512'(lm128), 512'(4'b1000));
    chk("last32", 512'(lm32), 512'(16'h8000));
    chk("wrap128", 512'(wrap), 512'(m_wrap));
    chk("wrap32", 512'(wrap32), 512'(m_wrap));
  endtask

  logic [255:0] gk, rk;
  logic [127:0] gd, rd;
  int           lat;

  initial begin
    rst = 1; set_key = 0; set_count = 0; start_enc = 0; key_len = 0;
    data_in = '0; key_in = '0; rdy = 1; rdy32 = 1;
    m_key = '0; m_klen = 0; m_nonce = '0; m_ctr = '0; m_wrap = 0;
    gk = {4{64'h1234567890ABCDEF}};
    gd = {64'h0, 64'h1234567890ABCDEF};
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 512'(busy), 512'(0));
    chk("rst_vld", 512'(vld), 512'(0));
    chk("rst_last", 512'(last), 512'(0));
    chk("rst_data", 512'(dout), 512'(0));
    chk("rst_wrap", 512'(wrap), 512'(0));
    chk("rst_busy32", 512'(busy32), 512'(0));
    chk("rst_data32", 512'(dout32), 512'(0));
    rst = 0;
    @(posedge clk); #1;

    // No SET_KEY yet: all-zero key, zero nonce and counter.
    run_block(0, 0, '0, 0, '0, 0, lat);

    // Golden vector, config in the same cycle as START_ENC.
    run_block(1, 1, gk, 0, gd, 0, lat);
    chk("latency", 512'(lat), 512'(22));
    chk("gold_c0", 512'(q128[0]), 512'(128'hdf8db6c12f790bfbef7da88d5d04e680));
    chk("gold_c1", 512'(q128[1]), 512'(128'h44cdfda43839020d407db3dad7e5b67f));
    chk("gold_c2", 512'(q128[2]), 512'(128'h16a4a8721524a56fda7e0a6b26d31087));
    chk("gold_c3", 512'(q128[3]), 512'(128'h12578220342d7c2f68a8e8e7cfb1543d));
    chk("gold32_c0", 512'(q32[0]), 512'(32'h5d04e680));

    // Auto-incremented counter.
    run_block(0, 0, gk, 0, '0, 0, lat);
    chk("gold_next_c0", 512'(q128[0]), 512'(128'he3ab8c19ec68ee0f47111a42bfb16625));

    // Random keys/nonces/counters under backpressure.
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < 8; i++) rk[32*i +: 32] = $urandom;
      for (int i = 0; i < 4; i++) rd[32*i +: 32] = $urandom;
      run_block(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rk,
                1'($urandom_range(0, 1)), rd, 1, lat);
    end

    // Counter wrap: sticky flag, next block uses counter 0.
    rd[63:0]   = {$urandom, $urandom};
    rd[127:64] = 64'hFFFF_FFFF_FFFF_FFFF;
    run_block(0, 1, '0, 0, rd, 1, lat);
    run_block(0, 0, '0, 0, '0, 1, lat);
    set_count = 1; data_in = gd;
    @(posedge clk); #1;
    set_count = 0;
    m_ctr = gd[127:64]; m_nonce = gd[63:0]; m_wrap = 0;
    chk("wrap_clear", 512'(wrap), 512'(0));

    // Reset during ROUND aborts the block.
    set_key = 1; set_count = 1; start_enc = 1; key_in = gk; key_len = 0; data_in = gd;
    @(posedge clk); #1;
    set_key = 0; set_count = 0; start_enc = 0;
    repeat (6) @(posedge clk);
    #1;
    rst = 1;
    @(negedge clk);
    chk("abort_busy", 512'(busy), 512'(0));
    chk("abort_vld", 512'(vld), 512'(0));
    chk("abort_last", 512'(last), 512'(0));
    chk("abort_data", 512'(dout), 512'(0));
    chk("abort_wrap", 512'(wrap), 512'(0));
    chk("abort_busy32", 512'(busy32), 512'(0));
    @(posedge clk); #1;
    rst = 0;
    m_key = '0; m_klen = 0; m_nonce = '0; m_ctr = '0; m_wrap = 0;
    @(posedge clk); #1;
    chk("abort_idle_vld", 512'(vld | vld32), 512'(0));
    run_block(1, 1, gk, 0, gd, 0, lat);
    chk("rst_gold_c0", 512'(q128[0]), 512'(128'hdf8db6c12f790bfbef7da88d5d04e680));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
